move_scan_seq: RTL
==================

MOVE_SCAN_SEQ -- requirements
Module: move_scan_seq

Interface
REQ-001 SHALL have parameter FILES, default 8, meaning files per rank (power of two, 2..16).
REQ-002 SHALL have parameter RANKS, default 8, meaning ranks scanned (power of two, 2..16).
REQ-003 SHALL have parameter PRIO_W, default 3, meaning priority width; SQ_W = log2(FILES*RANKS), square index = rank*FILES + file.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  begin enumeration (sampled in IDLE only).
REQ-007 SHALL have port clear_mask  input  1  sampled with start; 1 = clear emitted-mask first.
REQ-008 SHALL have port flip  input  1  sampled with start; 1 = report squares XORed with all-ones (rotated board).
REQ-009 SHALL have port abort  input  1  return to IDLE from any state.
REQ-010 SHALL have port prio_in  input  FILES*RANKS*PRIO_W  per-square priority, square s at bits [PRIO_W*s +: PRIO_W], stable while busy.
REQ-011 SHALL have port out_valid  output  1  result presented.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_square  output  SQ_W  best square (flip applied).
REQ-014 SHALL have port out_prio  output  PRIO_W  priority of out_square.
REQ-015 SHALL have port done  output  1  one-cycle pulse: no unmasked nonzero priority remains.
REQ-016 SHALL have port busy  output  1  high in SCAN and PRESENT.
REQ-017 SHALL have port emitted  output  SQ_W+1  count of squares masked since last clear.

Function
REQ-018 SHALL implement states IDLE, SCAN, PRESENT; all outputs registered.
REQ-019 IDLE: start=1 and abort=0 -> SCAN, rank counter 0, best_prio 0, best_sq 0; mask and emitted cleared if clear_mask=1; flip latched.
REQ-020 SCAN: one rank per cycle, ranks 0..RANKS-1 ascending; per file ascending, effective prio = 0 if masked else prio_in; replace best only if effective prio > best_prio (strict; lowest index wins ties).
REQ-021 SCAN at rank RANKS-1 with final best_prio = 0: done=1 for exactly one cycle, -> IDLE, out_valid stays 0.
REQ-022 SCAN at rank RANKS-1 with final best_prio > 0: -> PRESENT, out_valid=1, out_prio=best_prio, out_square=best_sq XOR (latched flip ? all-ones : 0).
REQ-023 Latency: out_valid or done asserts RANKS cycles after the edge that samples start or a handshake.
REQ-024 PRESENT: out_valid, out_square, out_prio held stable while out_ready=0.
REQ-025 PRESENT with out_valid&out_ready at an edge: set mask[best_sq] (unflipped index), emitted+1, out_valid=0, -> SCAN rank 0 with best cleared (auto-continue).
REQ-026 abort=1: -> IDLE next edge, out_valid=0, done=0, mask/emitted retained; abort overrides start and handshake in the same cycle; no effect in IDLE.
REQ-027 start while busy SHALL be ignored; clear_mask and flip ignored unless start accepted.
REQ-028 Priority 0 squares SHALL never be emitted; emitted cannot exceed FILES*RANKS.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, mask=0, emitted=0, rank=0, out_valid=0, out_square=0, out_prio=0, done=0, busy=0, latched flip=0, including mid-SCAN or mid-PRESENT.
REQ-030 After rst_n deasserts, first start SHALL be accepted on the next rising edge.

Verification (FILES=8, RANKS=8, PRIO_W=3)
REQ-031 All prio 0, start+clear_mask -> no out_valid; done pulses 1 cycle, 8 cycles after start edge; busy low after.
REQ-032 prio sq10=5, sq20=5, sq50=6, out_ready=1 -> emits 50/6, 10/5, 20/5, then done; emitted=3.
REQ-033 sq50=6, out_ready low 5 cycles -> out_valid and out_square=50 stable 5 cycles, emitted stays 0 until handshake.
REQ-034 flip=1, sq3=2 only -> out_square=60, out_prio=2; after handshake done pulses, emitted=1.
REQ-035 abort during SCAN rank 4 after one emission -> IDLE, out_valid 0; start with clear_mask=0 -> previously emitted square not re-emitted.
REQ-036 rst_n low while PRESENT -> out_valid, out_square, busy 0 without clock edge; emitted=0.

Source files
------------

// File: rtl/move_scan_seq.sv
// move_scan_seq - rank-by-rank priority scan that emits the best unmasked square, masks it and continues.
module move_scan_seq #(
  parameter int FILES  = 8,
  parameter int RANKS  = 8,
  parameter int PRIO_W = 3,
  localparam int N      = FILES * RANKS,
  localparam int SQ_W   = $clog2(N),
  localparam int RANK_W = $clog2(RANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear_mask,
  input  logic                  flip,
  input  logic                  abort,
  input  logic [N*PRIO_W-1:0]   prio_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SQ_W-1:0]       out_square,
  output logic [PRIO_W-1:0]     out_prio,
  output logic                  done,
  output logic                  busy,
  output logic [SQ_W:0]         emitted
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PRESENT} state_t;

  state_t              r_state;
  logic [RANK_W-1:0]   r_rank;
  logic [PRIO_W-1:0]   r_best_prio;
  logic [SQ_W-1:0]     r_best_sq;
  logic [N-1:0]        r_mask;
  logic [SQ_W:0]       r_emitted;
  logic                r_flip;
  logic                r_out_valid;
  logic [SQ_W-1:0]     r_out_square;
  logic [PRIO_W-1:0]   r_out_prio;
  logic                r_done;
  logic                r_busy;

  logic [PRIO_W-1:0]   w_best_prio;
  logic [SQ_W-1:0]     w_best_sq;
  logic [SQ_W-1:0]     w_sq;
  logic [PRIO_W-1:0]   w_eff;
  logic                w_last_rank;

  // Fold the current rank into the running best; strict compare keeps the lowest index on ties.
  always_comb begin
    w_best_prio = r_best_prio;
    w_best_sq   = r_best_sq;
    w_sq        = '0;
    w_eff       = '0;
    for (int f = 0; f < FILES; f++) begin
      w_sq  = SQ_W'(int'(r_rank) * FILES + f);
      w_eff = r_mask[w_sq] ? '0 : prio_in[PRIO_W*w_sq +: PRIO_W];
      if (w_eff > w_best_prio) begin
        w_best_prio = w_eff;
        w_best_sq   = w_sq;
      end
    end
  end

  assign w_last_rank = (r_rank == RANK_W'(RANKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rank       <= '0;
      r_best_prio  <= '0;
      r_best_sq    <= '0;
      r_mask       <= '0;
      r_emitted    <= '0;
      r_flip       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_square <= '0;
      r_out_prio   <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort && r_state != S_IDLE) begin
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state     <= S_SCAN;
              r_rank      <= '0;
              r_best_prio <= '0;
              r_best_sq   <= '0;
              r_flip      <= flip;
              r_busy      <= 1'b1;
              if (clear_mask) begin
                r_mask    <= '0;
                r_emitted <= '0;
              end
            end
          end
          S_SCAN: begin
            r_best_prio <= w_best_prio;
            r_best_sq   <= w_best_sq;
            if (!w_last_rank) begin
              r_rank <= r_rank + RANK_W'(1);
            end else if (w_best_prio == '0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state      <= S_PRESENT;
              r_out_valid  <= 1'b1;
              r_out_prio   <= w_best_prio;
              r_out_square <= w_best_sq ^ {SQ_W{r_flip}};
            end
          end
          S_PRESENT: begin
            if (out_ready) begin
              r_mask[r_best_sq] <= 1'b1;
              r_emitted         <= r_emitted + (SQ_W+1)'(1);
              r_out_valid       <= 1'b0;
              r_state           <= S_SCAN;
              r_rank            <= '0;
              r_best_prio       <= '0;
              r_best_sq         <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_square = r_out_square;
  assign out_prio   = r_out_prio;
  assign done       = r_done;
  assign busy       = r_busy;
  assign emitted    = r_emitted;

endmodule
